// File: rtl/muldiv_hilo_pkg.sv
// Shared definitions for the iterative multiply/divide unit and its HI/LO pair.
package muldiv_hilo_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  localparam int MD_STEPS = 32;

  function automatic logic md_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_hilo_if.sv
// Execute-stage port bundle between the pipeline (master) and the mul/div unit (slave).
interface muldiv_hilo_if #(parameter int WIDTH = 32);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output hi, lo, busy, done
  );

endinterface

// File: rtl/muldiv_sign.sv
// Conditional two's-complement negation, either as two independent halves
// (operand magnitudes, quotient/remainder) or as one double-width value (product).
module muldiv_sign #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] x,
  input  logic               split,
  input  logic               neg_hi,
  input  logic               neg_lo,
  output logic [2*WIDTH-1:0] y
);

  logic [WIDTH-1:0] x_hi;
  logic [WIDTH-1:0] x_lo;
  logic [WIDTH-1:0] y_hi;
  logic [WIDTH-1:0] y_lo;
  logic             hi_inc;

  // In double-width mode the +1 of the low half only carries into the high half when the low half is zero.
  always_comb begin
    x_hi   = x[2*WIDTH-1:WIDTH];
    x_lo   = x[WIDTH-1:0];
    hi_inc = split | (x_lo == '0);
    y_lo   = neg_lo ? (~x_lo + WIDTH'(1)) : x_lo;
    y_hi   = neg_hi ? (~x_hi + WIDTH'(hi_inc)) : x_hi;
    y      = {y_hi, y_lo};
  end

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative radix-2 multiply / restoring divide unit owning the HI/LO registers.
module muldiv_hilo
  import muldiv_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_hilo_if.slave  bus
);

  md_state_e          state;
  md_state_e          state_n;
  logic [5:0]         cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               is_div_r;
  logic               res_sign;
  logic               rem_sign;
  logic               done_r;

  logic               load;
  logic               step;
  logic               fix;
  logic               move;
  logic               launch_div;
  logic               launch_signed;

  logic [2*WIDTH-1:0] sgn_x;
  logic [2*WIDTH-1:0] sgn_y;
  logic               sgn_split;
  logic               sgn_neg_hi;
  logic               sgn_neg_lo;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    move    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_n = CALC;
        end else begin
          move    = 1'b1;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == 6'(MD_STEPS - 1)) state_n = FIX;
      end
      FIX: begin
        fix     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // The sign unit takes magnitudes of the incoming operands in IDLE and fixes up the result in FIX.
  always_comb begin
    launch_div    = md_is_div(bus.op);
    launch_signed = md_is_signed(bus.op);
    if (state == IDLE) begin
      sgn_x      = {bus.a, bus.b};
      sgn_split  = 1'b1;
      sgn_neg_hi = launch_signed & bus.a[WIDTH-1];
      sgn_neg_lo = launch_signed & bus.b[WIDTH-1];
    end else begin
      sgn_x      = is_div_r ? {rem, acc[WIDTH-1:0]} : acc;
      sgn_split  = is_div_r;
      sgn_neg_hi = is_div_r ? rem_sign : res_sign;
      sgn_neg_lo = res_sign;
    end
  end

  muldiv_sign #(.WIDTH(WIDTH)) u_sign (
    .x      (sgn_x),
    .split  (sgn_split),
    .neg_hi (sgn_neg_hi),
    .neg_lo (sgn_neg_lo),
    .y      (sgn_y)
  );

  // A remainder fits in WIDTH bits once the divisor is subtracted, so only the compare needs the extra bit.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    div_shift = {rem, acc[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mcand};
    div_rem_n = div_ge ? (div_shift[WIDTH-1:0] - mcand) : div_shift[WIDTH-1:0];
  end

  // A zero divisor yields an all-ones quotient naturally, so its sign flip is suppressed to keep LO = -1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      rem      <= '0;
      is_div_r <= 1'b0;
      res_sign <= 1'b0;
      rem_sign <= 1'b0;
    end else if (load) begin
      cnt      <= '0;
      rem      <= '0;
      is_div_r <= launch_div;
      mcand    <= launch_div ? sgn_y[WIDTH-1:0] : sgn_y[2*WIDTH-1:WIDTH];
      acc      <= {{WIDTH{1'b0}}, (launch_div ? sgn_y[2*WIDTH-1:WIDTH] : sgn_y[WIDTH-1:0])};
      res_sign <= launch_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1])
                  & ~(launch_div & (bus.b == '0));
      rem_sign <= launch_signed & launch_div & bus.a[WIDTH-1];
    end else if (step) begin
      cnt <= cnt + 6'd1;
      if (is_div_r) begin
        rem <= div_rem_n;
        acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ge};
      end else if (acc[0]) begin
        acc <= {mul_sum, acc[WIDTH-1:1]};
      end else begin
        acc <= {1'b0, acc[2*WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= fix;
      if (fix) begin
        hi_r <= sgn_y[2*WIDTH-1:WIDTH];
        lo_r <= sgn_y[WIDTH-1:0];
      end else if (move) begin
        if (bus.mthi) hi_r <= bus.wdata;
        if (bus.mtlo) lo_r <= bus.wdata;
      end
    end
  end

  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench: per-cycle comparison against an arithmetic HI/LO model plus literal test-plan checks.
module tb_muldiv_hilo;
  import muldiv_hilo_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  muldiv_hilo_if bus ();

  muldiv_hilo dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  int          m_left = 0;
  logic        m_done = 1'b0;

  function automatic void refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
    longint          sa;
    longint          sb;
    longint          p;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    hi = '0;
    lo = '0;
    case (op)
      MD_MULT:  begin p = sa * sb; {hi, lo} = p; end
      MD_MULTU: begin up = ua * ub; {hi, lo} = up; end
      MD_DIV: begin
        if (b == 32'h0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      end
      default: begin
        if (b == 32'h0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = 32'(ua / ub); hi = 32'(ua % ub); end
      end
    endcase
  endfunction

  // Timing model: a result lands 33 edges after the accepting edge; moves only land when idle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi   = '0;
      m_lo   = '0;
      m_left = 0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_hi   = p_hi;
          m_lo   = p_lo;
          m_done = 1'b1;
        end
      end else if (bus.start) begin
        refModel(bus.op, bus.a, bus.b, p_hi, p_lo);
        m_left = 33;
      end else begin
        if (bus.mthi) m_hi = bus.wdata;
        if (bus.mtlo) m_lo = bus.wdata;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model_hi",   bus.hi, m_hi);
    checkOutput("model_lo",   bus.lo, m_lo);
    checkOutput("model_busy", 32'(bus.busy), 32'(m_left > 0));
    checkOutput("model_done", 32'(bus.done), 32'(m_done));
  end

  // Called at a negedge; the following posedge is the accepting edge E0.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] mv);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.mthi  = mv[1];
    bus.mtlo  = mv[0];
    bus.wdata = $urandom;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.op    = 2'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic waitDone(input int from, output int cycles);
    cycles = from;
    while (bus.done !== 1'b1 && cycles < 60) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset_hi",   bus.hi, 32'h0);
    checkOutput("reset_lo",   bus.lo, 32'h0);
    checkOutput("reset_busy", 32'(bus.busy), 32'h0);
    checkOutput("reset_done", 32'(bus.done), 32'h0);
    rst_n = 1'b1;

    applyStimulus(MD_MULT, 32'hFFFF_FFFD, 32'h5, 2'b00);
    waitDone(0, lat);
    checkOutput("mult_latency", 32'(lat), 32'd33);
    checkOutput("mult_hi", bus.hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", bus.lo, 32'hFFFF_FFF1);

    applyStimulus(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
    waitDone(0, lat);
    checkOutput("multu_b2b_latency", 32'(lat), 32'd33);
    checkOutput("multu_hi", bus.hi, 32'hFFFF_FFFE);
    checkOutput("multu_lo", bus.lo, 32'h0000_0001);

    applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'h2, 2'b00);
    waitDone(0, lat);
    checkOutput("div_neg_hi", bus.hi, 32'hFFFF_FFFF);
    checkOutput("div_neg_lo", bus.lo, 32'hFFFF_FFFD);

    applyStimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00);
    waitDone(0, lat);
    checkOutput("div_wrap_hi", bus.hi, 32'h0);
    checkOutput("div_wrap_lo", bus.lo, 32'h8000_0000);

    applyStimulus(MD_DIVU, 32'h7, 32'h0, 2'b00);
    waitDone(0, lat);
    checkOutput("divz_latency", 32'(lat), 32'd33);
    checkOutput("divz_hi", bus.hi, 32'h0000_0007);
    checkOutput("divz_lo", bus.lo, 32'hFFFF_FFFF);

    bus.mthi  = 1'b1;
    bus.wdata = 32'h0000_1234;
    @(negedge clk);
    bus.mthi  = 1'b0;
    checkOutput("mthi_hi", bus.hi, 32'h0000_1234);
    checkOutput("mthi_lo", bus.lo, 32'hFFFF_FFFF);

    // start and mtlo strobed at E5 of a running MULT must be ignored
    applyStimulus(MD_MULT, 32'h6, 32'h7, 2'b00);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.mtlo  = 1'b1;
    bus.op    = MD_DIVU;
    bus.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mtlo  = 1'b0;
    waitDone(5, lat);
    checkOutput("busy_ignore_latency", 32'(lat), 32'd33);
    checkOutput("busy_ignore_hi", bus.hi, 32'h0);
    checkOutput("busy_ignore_lo", bus.lo, 32'd42);
    @(negedge clk);
    checkOutput("busy_ignore_idle", 32'(bus.busy), 32'h0);

    applyStimulus(MD_DIVU, 32'd100, 32'd7, 2'b00);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'h0);
    checkOutput("abort_hi", bus.hi, 32'h0);
    checkOutput("abort_lo", bus.lo, 32'h0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("abort_done", 32'(bus.done), 32'h0);
    end
    rst_n = 1'b1;
    applyStimulus(MD_DIVU, 32'd100, 32'd7, 2'b00);
    waitDone(0, lat);
    checkOutput("after_reset_hi", bus.hi, 32'd2);
    checkOutput("after_reset_lo", bus.lo, 32'd14);

    for (int n = 0; n < 40; n++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        bus.mthi  = 1'($urandom_range(0, 1));
        bus.mtlo  = 1'($urandom_range(0, 1));
        bus.wdata = $urandom;
        @(negedge clk);
      end
      bus.mthi = 1'b0;
      bus.mtlo = 1'b0;
      rop = 2'($urandom);
      case ($urandom_range(0, 7))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'h0;
        2:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        3:       rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      applyStimulus(rop, ra, rb, 2'($urandom));
      waitDone(0, lat);
      checkOutput("rand_latency", 32'(lat), 32'd33);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

Iterative multiply/divide unit that owns the HI/LO register pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO. Sits in the execute stage. Its `hi`/`lo` outputs feed two inputs of the 8-way register-file write-data selector, which the MFHI/MFLO paths use. The pipeline stalls while `busy` is high.

## Interface
- `WIDTH`, 32, operand and HI/LO width. Only 32 is supported.
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  launch the operation selected by `op`; sampled in IDLE only
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `a`  in  32  rs operand (multiplicand / dividend)
- `b`  in  32  rt operand (multiplier / divisor)
- `mthi`  in  1  write `wdata` into HI
- `mtlo`  in  1  write `wdata` into LO
- `wdata`  in  32  MTHI/MTLO data
- `hi`  out  32  HI register
- `lo`  out  32  LO register
- `busy`  out  1  operation in progress; the pipeline must stall
- `done`  out  1  one-cycle pulse when HI/LO take a new result

## Operation
- States:
  - IDLE -> CALC on `start`.
  - CALC -> FIX after 32 steps.
  - FIX -> IDLE unconditionally.
- IDLE, `start` = 1:
  - Latch |a| and |b| for signed ops, raw values otherwise.
  - Latch the result sign and the remainder sign (= sign of a).
  - Clear the 6-bit step counter.
- CALC, multiply:
  - Radix-2 shift-add on a 64-bit accumulator, one bit per cycle.
- CALC, divide:
  - Restoring divide, one quotient bit per cycle.
  - 33-bit partial remainder.
- FIX:
  - Two's-complement negate the product if the result sign is 1 (signed ops only).
  - Negate the quotient if the signs of a and b differ.
  - Negate the remainder if the remainder sign is 1.
  - Write HI/LO; pulse `done`.
- Multiply result: HI = product[63:32], LO = product[31:0].
- Divide result: LO = quotient, HI = remainder. The remainder takes the dividend's sign (truncating division).
- Divide by zero (b = 0, DIV or DIVU):
  - Still runs the full latency.
  - LO = 0xFFFFFFFF, HI = a, unmodified.
- DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0. This falls out of the 32-bit wrap.
- `mthi`/`mtlo` act only in IDLE with `start` = 0. Both may assert together; each writes its own register.
- `start` together with `mthi`/`mtlo` in IDLE: `start` wins and the move is dropped.
- `start`, `mthi` and `mtlo` are ignored while not in IDLE.
- Operand inputs are don't-care after the `start` cycle.

## Timing
- Reset (async assert, sync-safe release):
  - State IDLE.
  - `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0.
  - Counter and all datapath registers cleared.
- Edge E0 samples `start`. `busy` is 1 from after E0 through after E32 (33 cycles).
- E1..E32: the 32 iteration steps. E32 moves the state to FIX.
- E33:
  - HI/LO are updated.
  - `busy` = 0, `done` = 1 for exactly that cycle.
  - State returns to IDLE.
- A new `start` is accepted in the `done` cycle, giving back-to-back operations every 34 cycles.
- MTHI/MTLO: `hi`/`lo` change at the edge that samples the strobe, so they are visible the next cycle.
- Reset asserted mid-operation:
  - Immediate abort; HI/LO return to 0.
  - No `done` pulse.
  - The partially computed result is discarded.
- `hi`/`lo` hold their previous values throughout CALC/FIX until E33.

## Structure
- The shared CPU package holds:
  - The `op` encodings: `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`.
  - The state typedef: IDLE, CALC, FIX.
  - `MD_STEPS` = 32.
- One sub-module is natural: `muldiv_sign`, combinational.
  - Produces absolute values at launch.
  - Produces conditional negation at FIX.
  - Shared by both paths.
- The accumulator, counter and FSM stay in `muldiv_hilo`.

## Test plan
- MULT a = 0xFFFFFFFD (-3), b = 5 -> `done` at E33; HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- MULTU a = b = 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001.
- Signed divides:
  - DIV a = 0xFFFFFFF9 (-7), b = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIV a = 0x80000000, b = 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- DIVU a = 7, b = 0 -> `busy` 33 cycles, then LO = 0xFFFFFFFF, HI = 0x00000007.
- Move and busy handling:
  - In IDLE, `mthi` with `wdata` = 0x00001234 -> `hi` = 0x1234 next cycle, `lo` unchanged.
  - `start` or `mtlo` pulsed at E5 of a MULT -> ignored; result and latency unchanged.
- DIVU 100/7 started, `rst_n` low at E10 -> `busy`, `hi` and `lo` go to 0 immediately; no `done`.
  - After release, DIVU 100/7 -> LO = 14, HI = 2.
